// File: rtl/cola_solicitudes_if.sv
// Request-queue interface between the button front end (master) and the
// request store (slave). Clock and reset stay outside as plain ports.
interface cola_solicitudes_if;
    logic       agregar;
    logic [3:0] boton_pres;
    logic       obtener;
    logic [1:0] piso_m;
    logic [1:0] accion_m;
    logic       puertas_m;
    logic [3:0] memoria;
    logic       vacio;
    logic       lleno;
    logic [4:0] cuenta;
    logic       desborde;

    modport master (
        output agregar, boton_pres, obtener, piso_m, accion_m, puertas_m,
        input  memoria, vacio, lleno, cuenta, desborde
    );

    modport slave (
        input  agregar, boton_pres, obtener, piso_m, accion_m, puertas_m,
        output memoria, vacio, lleno, cuenta, desborde
    );
endinterface

// File: rtl/cola_solicitudes.sv
// cola_solicitudes: ordered, duplicate-free store of elevator button requests.
// The oldest pending code is shown on memoria and retired when the car opens
// its doors on that code's floor.
// Optional macro PRIORIDAD_PASO_EN: a qualifying obtener removes every pending
// request for the current floor and compacts the survivors in order.
module cola_solicitudes #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic              clk,
    input logic              rst,
    cola_solicitudes_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {VACIO, PARCIAL, LLENO} estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [4:0]    cuenta_q, cuenta_d;
    logic          desb_q, desb_d;

    logic [DEPTH-1:0] valido, quitar, conservar;
    logic [AW-1:0]    desplaz;
    logic [4:0]       n_quitar, cuenta_resto;
    logic             codigo_ok, duplicado, push_ok;
    logic             unused_accion;

    // Direction of travel does not influence which requests are retired.
    assign unused_accion = ^bus.accion_m;

    // Floor served by each button code; codes outside 1..10 are never stored.
    function automatic logic [1:0] piso_de(input logic [CW-1:0] code);
        case (code)
            4'd1, 4'd5:       piso_de = 2'd0;
            4'd2, 4'd6, 4'd7: piso_de = 2'd1;
            4'd3, 4'd8, 4'd9: piso_de = 2'd2;
            4'd4, 4'd10:      piso_de = 2'd3;
            default:          piso_de = 2'd0;
        endcase
    endfunction

    // Decide which entries leave, whether the incoming code is new, and the resulting count.
    always_comb begin
        valido       = '0;
        quitar       = '0;
        conservar    = '0;
        desplaz      = '0;
        n_quitar     = '0;
        duplicado    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            desplaz   = AW'(i) - rd_q;
            valido[i] = ({{(5-AW){1'b0}}, desplaz} < cuenta_q);
        end
`ifdef PRIORIDAD_PASO_EN
        for (int i = 0; i < DEPTH; i++) begin
            quitar[i] = bus.obtener && bus.puertas_m && valido[i] &&
                        (piso_de(mem_q[i]) == bus.piso_m);
        end
`else
        quitar[rd_q] = bus.obtener && bus.puertas_m && (cuenta_q != 5'd0) &&
                       (piso_de(mem_q[rd_q]) == bus.piso_m);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            conservar[i] = valido[i] && !quitar[i];
            n_quitar     = n_quitar + {4'b0, quitar[i]};
            if (conservar[i] && (mem_q[i] == bus.boton_pres)) begin
                duplicado = 1'b1;
            end
        end
        cuenta_resto = cuenta_q - n_quitar;
        codigo_ok    = (bus.boton_pres != 4'd0) && (bus.boton_pres <= 4'd10);
        push_ok      = bus.agregar && codigo_ok && !duplicado && (cuenta_resto != 5'(DEPTH));
        desb_d       = bus.agregar && codigo_ok && !duplicado && (cuenta_resto == 5'(DEPTH));
        cuenta_d     = cuenta_resto + {4'b0, push_ok};
    end

`ifdef PRIORIDAD_PASO_EN
    // Rebuild the queue linearly from slot 0: survivors in original order, then the new code.
    always_comb begin
        int            k;
        logic [AW-1:0] src;
        k   = 0;
        src = '0;
        mem_d = mem_q;
        for (int j = 0; j < DEPTH; j++) begin
            src = rd_q + AW'(j);
            if (conservar[src]) begin
                mem_d[AW'(k)] = mem_q[src];
                k = k + 1;
            end
        end
        if (push_ok) begin
            mem_d[AW'(k)] = bus.boton_pres;
        end
        rd_d = '0;
        wr_d = cuenta_d[AW-1:0];
    end
`else
    // Circular buffer: retire at the read pointer, append at the write pointer.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (quitar[rd_q]) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_q] = bus.boton_pres;
            wr_d        = wr_q + 1'b1;
        end
    end
`endif

    // Occupancy state follows the count the queue will hold after this edge.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            VACIO:   if (cuenta_d != 5'd0) estado_d = (cuenta_d == 5'(DEPTH)) ? LLENO : PARCIAL;
            PARCIAL: if (cuenta_d == 5'd0) estado_d = VACIO;
                     else if (cuenta_d == 5'(DEPTH)) estado_d = LLENO;
            LLENO:   if (cuenta_d != 5'(DEPTH)) estado_d = (cuenta_d == 5'd0) ? VACIO : PARCIAL;
            default: estado_d = VACIO;
        endcase
    end

    // State registers; reset discards every pending request at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= VACIO;
            rd_q     <= '0;
            wr_q     <= '0;
            cuenta_q <= '0;
            desb_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            estado_q <= estado_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cuenta_q <= cuenta_d;
            desb_q   <= desb_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.memoria  = (estado_q == VACIO) ? 4'd0 : mem_q[rd_q];
    assign bus.vacio    = (estado_q == VACIO);
    assign bus.lleno    = (estado_q == LLENO);
    assign bus.cuenta   = cuenta_q;
    assign bus.desborde = desb_q;
endmodule

// File: tb/tb_cola_solicitudes.sv
// Testbench for cola_solicitudes: a queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_cola_solicitudes;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cola_solicitudes_if bus();

    cola_solicitudes #(.DEPTH(DEPTH), .CW(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending requests as an ordered list of codes.
    int q[$];
    int kept[$];
    int floorTab[16] = '{0, 0, 1, 2, 3, 0, 1, 1, 2, 2, 3, 0, 0, 0, 0, 0};
    bit expDesb;
    bit found;

    task automatic compareField(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input int expMem, input int expCuenta,
                               input int expVacio, input int expLleno, input int expDesbv);
        compareField({name, " memoria"},  int'(bus.memoria),  expMem);
        compareField({name, " cuenta"},   int'(bus.cuenta),   expCuenta);
        compareField({name, " vacio"},    int'(bus.vacio),    expVacio);
        compareField({name, " lleno"},    int'(bus.lleno),    expLleno);
        compareField({name, " desborde"}, int'(bus.desborde), expDesbv);
    endtask

    task automatic applyStimulus(input logic a, input int code, input logic o,
                                 input int piso, input logic doors);
        @(negedge clk);
        #2;
        bus.agregar    = a;
        bus.boton_pres = 4'(code);
        bus.obtener    = o;
        bus.piso_m     = 2'(piso);
        bus.puertas_m  = doors;
        @(posedge clk);
        #1;
        bus.agregar = 1'b0;
        bus.obtener = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Model update: retire first, then consider the incoming code.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            expDesb = 1'b0;
        end else begin
            expDesb = 1'b0;
            if (bus.obtener && bus.puertas_m && q.size() > 0) begin
`ifdef PRIORIDAD_PASO_EN
                kept.delete();
                foreach (q[i]) if (floorTab[q[i]] != int'(bus.piso_m)) kept.push_back(q[i]);
                q = kept;
`else
                if (floorTab[q[0]] == int'(bus.piso_m)) void'(q.pop_front());
`endif
            end
            if (bus.agregar && bus.boton_pres >= 1 && bus.boton_pres <= 10) begin
                found = 1'b0;
                foreach (q[i]) if (q[i] == int'(bus.boton_pres)) found = 1'b1;
                if (!found) begin
                    if (q.size() < DEPTH) q.push_back(int'(bus.boton_pres));
                    else expDesb = 1'b1;
                end
            end
        end
    end

    // Every cycle, the registered outputs must match the model.
    always @(negedge clk) begin
        compareField("model memoria",  int'(bus.memoria),  (q.size() > 0) ? q[0] : 0);
        compareField("model cuenta",   int'(bus.cuenta),   q.size());
        compareField("model vacio",    int'(bus.vacio),    (q.size() == 0) ? 1 : 0);
        compareField("model lleno",    int'(bus.lleno),    (q.size() == DEPTH) ? 1 : 0);
        compareField("model desborde", int'(bus.desborde), int'(expDesb));
    end

    initial begin
        bus.agregar    = 1'b0;
        bus.boton_pres = 4'd0;
        bus.obtener    = 1'b0;
        bus.piso_m     = 2'd0;
        bus.accion_m   = 2'd0;
        bus.puertas_m  = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        checkOutput("reset", 0, 0, 1, 0, 0);

        $display("[TB] scenario: dedupe");
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(1, 7, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        checkOutput("dedupe", 3, 2, 0, 0, 0);

        $display("[TB] scenario: invalid codes");
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 12, 0, 0, 0);
        checkOutput("invalid codes", 0, 0, 1, 0, 0);

        $display("[TB] scenario: fill and overflow");
        doReset();
        for (int c = 1; c <= DEPTH; c++) applyStimulus(1, c, 0, 0, 0);
        checkOutput("full", 1, 8, 0, 1, 0);
        applyStimulus(1, 9, 0, 0, 0);
        checkOutput("overflow pulse", 1, 8, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pulse ends", 1, 8, 0, 1, 0);
        applyStimulus(1, 9, 1, 0, 1);
`ifndef PRIORIDAD_PASO_EN
        checkOutput("pop push full", 2, 8, 0, 1, 0);
`endif

        $display("[TB] scenario: floor match");
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 2, 1);
`ifndef PRIORIDAD_PASO_EN
        checkOutput("head 4", 4, 6, 0, 0, 0);
`endif
        applyStimulus(0, 0, 1, 1, 1);
`ifndef PRIORIDAD_PASO_EN
        checkOutput("wrong floor", 4, 6, 0, 0, 0);
`endif
        applyStimulus(0, 0, 1, 3, 1);
`ifndef PRIORIDAD_PASO_EN
        checkOutput("right floor", 5, 5, 0, 0, 0);
`endif
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 2, 1);
        applyStimulus(0, 0, 1, 2, 0);
`ifndef PRIORIDAD_PASO_EN
        checkOutput("tail 9 doors shut", 9, 1, 0, 0, 0);
`endif

        $display("[TB] scenario: async reset");
        doReset();
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 6, 0, 0, 0);
        checkOutput("before reset", 2, 3, 0, 0, 0);
        @(negedge clk);
        #2;
        bus.agregar    = 1'b1;
        bus.boton_pres = 4'd8;
        rst_n          = 1'b0;
        #1;
        checkOutput("async reset", 0, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        bus.agregar = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after release", 0, 0, 1, 0, 0);

        $display("[TB] scenario: pass-by priority");
        doReset();
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 7, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1);
`ifdef PRIORIDAD_PASO_EN
        checkOutput("paso removes floor 1", 4, 2, 0, 0, 0);
`else
        checkOutput("head only no pop", 4, 4, 0, 0, 0);
`endif
        applyStimulus(0, 0, 1, 3, 1);
`ifdef PRIORIDAD_PASO_EN
        checkOutput("paso next head", 3, 1, 0, 0, 0);
`else
        checkOutput("head pop next", 2, 3, 0, 0, 0);
`endif

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
